day03_pick_engine: RTL and testbench

- Generalised greedy "largest K-digit subsequence" solver for AoC day 3 style input.
- Consumes an ASCII byte stream over a valid/ready handshake.
- Double-buffers per-line digit-position bitmaps, so line i+1 loads while line i is processed.
- Runs two independently configurable pick passes (A, B) per line and accumulates both sums; reports sticky error flags and a line count.

---
 rtl/day03_pick_engine.sv | 194 +++++++++++++++++++
 tb/tb_day03_pick_engine.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/day03_pick_engine.sv
// rtl/day03_pick_engine.sv - largest K-digit subsequence solver over a byte stream
// Double-buffered digit bitmaps feed a two-pass greedy picker that accumulates per-line values.
module day03_pick_engine #(
    parameter int MAX_LINE_LEN = 128,
    parameter int LEN_W        = 8,
    parameter int MAX_PICK     = 16,
    parameter int ACC_W        = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       pick_len_a,
    input  logic [4:0]       pick_len_b,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] result_a,
    output logic [ACC_W-1:0] result_b,
    output logic [31:0]      line_count,
    output logic             err_overflow,
    output logic             err_short,
    output logic             done
);
    localparam int IDX_W  = $clog2(MAX_LINE_LEN);
    localparam int PICK_W = 5;

    typedef enum logic [2:0] {S_IDLE, S_PASS_A, S_ACC_A, S_PASS_B, S_ACC_B, S_DONE} state_t;

    logic [MAX_LINE_LEN-1:0] bitmap [2][10];
    logic [LEN_W-1:0]        line_len [2];
    logic [1:0]              full;
    logic                    load_buf, proc_buf, proc_buf_n, last_seen, release_buf;
    logic [LEN_W-1:0]        load_idx, new_len;
    logic [PICK_W-1:0]       pick_a, pick_b;
    logic                    is_digit, is_term, accept, store, eol;
    logic [3:0]              digit;

    assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign is_term  = (in_data == 8'h0A) || (in_data == 8'h00);
    assign digit    = in_data[3:0];
    // A line end needs the other buffer free, since it is where loading continues.
    assign in_ready = !done && !last_seen && !((is_term || in_last) && full[~load_buf]);
    assign accept   = in_valid && in_ready;
    assign store    = accept && is_digit && (load_idx < LEN_W'(MAX_LINE_LEN));
    assign eol      = accept && (is_term || in_last);
    assign new_len  = load_idx + LEN_W'(store);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int d = 0; d < 10; d++) bitmap[b][d] <= '0;
                line_len[b] <= '0;
            end
            full         <= '0;
            load_buf     <= 1'b0;
            load_idx     <= '0;
            last_seen    <= 1'b0;
            err_overflow <= 1'b0;
            pick_a <= (pick_len_a > PICK_W'(MAX_PICK)) ? PICK_W'(MAX_PICK) : pick_len_a;
            pick_b <= (pick_len_b > PICK_W'(MAX_PICK)) ? PICK_W'(MAX_PICK) : pick_len_b;
        end else begin
            if (store) begin
                bitmap[load_buf][digit][load_idx[IDX_W-1:0]] <= 1'b1;
                load_idx <= load_idx + LEN_W'(1);
            end
            if (accept && is_digit && !store) err_overflow <= 1'b1;
            if (accept && in_last) last_seen <= 1'b1;
            if (release_buf) full[proc_buf] <= 1'b0;
            if (eol && (new_len != '0)) begin
                line_len[load_buf] <= new_len;
                full[load_buf]     <= 1'b1;
                load_buf           <= ~load_buf;
                load_idx           <= '0;
                for (int d = 0; d < 10; d++) bitmap[~load_buf][d] <= '0;
            end
        end
    end

    state_t            state, state_n;
    logic [LEN_W-1:0]  scan, scan_n, cur_len, limit;
    logic [PICK_W-1:0] remaining, rem_n, cur_pick;
    logic [ACC_W-1:0]  val, val_n, acc_a, acc_a_n, acc_b, acc_b_n;
    logic [31:0]       lc_n;
    logic              err_short_n, is_short;
    logic [MAX_LINE_LEN-1:0] range_mask, masked, best_mask;
    logic [3:0]        best_d;
    logic [IDX_W-1:0]  best_p;

    // Greedy choice: highest digit in [scan, limit], earliest occurrence of it.
    always_comb begin
        cur_len    = line_len[proc_buf];
        cur_pick   = (state == S_PASS_B) ? pick_b : pick_a;
        limit      = cur_len - LEN_W'(remaining);
        is_short   = cur_len < LEN_W'(cur_pick);
        range_mask = '0;
        for (int i = 0; i < MAX_LINE_LEN; i++)
            range_mask[i] = (LEN_W'(i) >= scan) && (LEN_W'(i) <= limit);
        best_mask = '0;
        best_d    = '0;
        masked    = '0;
        for (int d = 0; d < 10; d++) begin
            masked = bitmap[proc_buf][d] & range_mask;
            if (|masked) begin
                best_mask = masked;
                best_d    = 4'(d);
            end
        end
        best_p = '0;
        for (int i = MAX_LINE_LEN - 1; i >= 0; i--)
            if (best_mask[i]) best_p = IDX_W'(i);
    end

    always_comb begin
        state_n     = state;
        scan_n      = scan;
        rem_n       = remaining;
        val_n       = val;
        acc_a_n     = acc_a;
        acc_b_n     = acc_b;
        lc_n        = line_count;
        err_short_n = err_short;
        proc_buf_n  = proc_buf;
        release_buf = 1'b0;
        case (state)
            S_IDLE: begin
                if (full[proc_buf]) begin
                    state_n = S_PASS_A;
                    rem_n   = pick_a;
                    scan_n  = '0;
                    val_n   = '0;
                end else if (last_seen) begin
                    state_n = S_DONE;
                end
            end
            S_PASS_A, S_PASS_B: begin
                if (is_short || (remaining == '0)) begin
                    val_n = '0;
                    if (is_short) err_short_n = 1'b1;
                    state_n = (state == S_PASS_A) ? S_ACC_A : S_ACC_B;
                end else begin
                    val_n  = val * ACC_W'(10) + ACC_W'(best_d);
                    scan_n = LEN_W'(best_p) + LEN_W'(1);
                    rem_n  = remaining - PICK_W'(1);
                    if (remaining == PICK_W'(1))
                        state_n = (state == S_PASS_A) ? S_ACC_A : S_ACC_B;
                end
            end
            S_ACC_A: begin
                acc_a_n = acc_a + val;
                rem_n   = pick_b;
                scan_n  = '0;
                val_n   = '0;
                state_n = S_PASS_B;
            end
            S_ACC_B: begin
                acc_b_n     = acc_b + val;
                lc_n        = line_count + 32'd1;
                release_buf = 1'b1;
                proc_buf_n  = ~proc_buf;
                state_n     = S_IDLE;
            end
            S_DONE: state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            scan       <= '0;
            remaining  <= '0;
            val        <= '0;
            acc_a      <= '0;
            acc_b      <= '0;
            line_count <= '0;
            err_short  <= 1'b0;
            proc_buf   <= 1'b0;
        end else begin
            state      <= state_n;
            scan       <= scan_n;
            remaining  <= rem_n;
            val        <= val_n;
            acc_a      <= acc_a_n;
            acc_b      <= acc_b_n;
            line_count <= lc_n;
            err_short  <= err_short_n;
            proc_buf   <= proc_buf_n;
        end
    end

    assign result_a = acc_a;
    assign result_b = acc_b;
    assign done     = (state == S_DONE);
endmodule

// File: tb/tb_day03_pick_engine.sv
// tb/tb_day03_pick_engine.sv - scoreboard bench for day03_pick_engine
module tb_day03_pick_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  pick_len_a = '0, pick_len_b = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0, in_last = 1'b0;
    logic        in_ready;
    logic [63:0] result_a, result_b;
    logic [31:0] line_count;
    logic        err_overflow, err_short, done;

    day03_pick_engine dut (
        .clk(clk), .rst(rst), .pick_len_a(pick_len_a), .pick_len_b(pick_len_b),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .result_a(result_a), .result_b(result_b), .line_count(line_count),
        .err_overflow(err_overflow), .err_short(err_short), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] ra;
        logic [63:0] rb;
        logic [31:0] lc;
        logic        ov;
        logic        sh;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   stalls  = 0;
    bit   checked = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            checked = 1'b0;
        end else if (done && !checked) begin
            checked = 1'b1;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_a", result_a, e.ra);
                chk("result_b", result_b, e.rb);
                chk("line_count", line_count, e.lc);
                chk("err_overflow", err_overflow, e.ov);
                chk("err_short", err_short, e.sh);
            end
        end
    end

    task automatic push_exp(input logic [63:0] ra, input logic [63:0] rb, input int lc,
                            input logic ov, input logic sh);
        exp_t e;
        e.ra = ra; e.rb = rb; e.lc = lc; e.ov = ov; e.sh = sh;
        sb.push_back(e);
    endtask

    task automatic do_reset(input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        pick_len_a = a; pick_len_b = b;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input bit hold);
        int n;
        @(negedge clk);
        in_data = b; in_valid = 1'b1; in_last = last;
        #1;
        n = 0;
        while (!in_ready && n < 500) begin
            stalls++;
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        if (!hold) begin
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0;
        end
    endtask

    task automatic send_str(input string s, input bit last_on_end, input bit hold);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], last_on_end && (i == s.len() - 1), hold);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    string t1 = "987654321111111\n811111111111119\n234234234234278\n818181911112111\n";

    initial begin
        do_reset(5'd2, 5'd12);
        #1;
        chk("rst_result_a", result_a, 0);
        chk("rst_result_b", result_b, 0);
        chk("rst_line_count", line_count, 0);
        chk("rst_done", done, 0);
        chk("rst_err_overflow", err_overflow, 0);
        chk("rst_err_short", err_short, 0);
        chk("rst_in_ready", in_ready, 1);

        push_exp(64'd357, 64'd3121910778619, 4, 1'b0, 1'b0);
        send_str(t1, 1'b1, 1'b0);
        wait_done();

        do_reset(5'd2, 5'd12);
        stalls = 0;
        push_exp(64'd357, 64'd3121910778619, 4, 1'b0, 1'b0);
        send_str(t1, 1'b1, 1'b1);
        wait_done();
        chk("backpressure_seen", (stalls > 0), 1);

        do_reset(5'd2, 5'd12);
        push_exp(64'd45, 64'd0, 1, 1'b0, 1'b1);
        send_str("12345", 1'b1, 1'b0);
        wait_done();

        do_reset(5'd3, 5'd3);
        push_exp(64'd999, 64'd999, 1, 1'b1, 1'b0);
        for (int i = 0; i < 130; i++) send_byte(8'h39, 1'b0, 1'b1);
        send_byte(8'h0A, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        wait_done();

        do_reset(5'd1, 5'd2);
        push_exp(64'd5, 64'd55, 1, 1'b0, 1'b0);
        send_str("\n\015\n55\015\n", 1'b1, 1'b0);
        wait_done();

        do_reset(5'd2, 5'd12);
        send_str("987654321111111\n8111", 1'b0, 1'b1);
        do_reset(5'd2, 5'd12);
        push_exp(64'd357, 64'd3121910778619, 4, 1'b0, 1'b0);
        send_str(t1, 1'b1, 1'b0);
        wait_done();

        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
